command_tx: RTL and testbench
=============================

Name: command_tx

Overview:
- UART command transmitter, 8N1. Takes one {address, 16-bit data} command over a valid/ready handshake and sends it as a 3-byte packet: address byte, then data[7:0], then data[15:8].
- Byte order and framing match the existing UART command receiver, so this block's uart_tx can drive that receiver's uart_rx line directly.
- Contains its own bit-level serializer with a baud divider; no separate tx primitive is required.

Parameters:
- BAUD_DIV, 128, i_clk cycles per UART bit. Legal range is 2 to 65535; values outside it are unsupported.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset; clock i_clk.
- cmd_valid  input  1  a command is presented on cmd_addr/cmd_data.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_addr  input  8  command address; sent as byte 0.
- cmd_data  input  16  command data; low byte sent as byte 1, high byte as byte 2.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while a packet is in flight, from the cycle after accept to the end of the last stop bit.
- pkt_done  output  1  one-cycle pulse when the final stop bit of byte 2 completes.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge):
  - uart_tx=1, cmd_ready=0, busy=0, pkt_done=0.
  - State goes to IDLE; all counters clear.
  - Reset mid-packet abandons the packet. uart_tx is high from the next edge, and no pkt_done is issued.
- Once rst=1, the first cycle in IDLE drives cmd_ready=1.
- Handshake:
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - At accept, {cmd_data[15:8], cmd_data[7:0], cmd_addr} is latched into a 24-bit packet register. The inputs may change freely afterwards.
  - cmd_ready=0 from the cycle after accept until the packet completes.
  - cmd_valid while cmd_ready=0 is ignored and not queued.
- State machine: IDLE -> START -> DATA -> STOP, with a byte index of 0..2.
  - IDLE: uart_tx=1. On accept go to START with byte index 0.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: uart_tx = current byte bit[bit index], LSB first, BAUD_DIV cycles per bit. After bit 7 go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles. Then:
    - if byte index < 2: increment byte index and go to START;
    - if byte index = 2: pulse pkt_done, go to IDLE, busy=0.
- Timing and latency:
  - The start bit of byte 0 begins on the cycle after accept.
  - Bytes are sent back-to-back with no inter-byte gap.
  - A packet occupies exactly 30*BAUD_DIV cycles of uart_tx.
- Back-to-back packets:
  - cmd_ready=1 on the cycle after the last stop bit ends.
  - If cmd_valid is held, the next accept occurs in that cycle, so the line is high for BAUD_DIV+1 cycles between packets.
  - pkt_done for a packet and accept of the next packet may coincide.
- Baud counter: counts 0..BAUD_DIV-1 and is width-sized for BAUD_DIV. It reloads to 0 at every bit boundary and at every state entry. No drift is allowed across 30 bits.

Test Plan:
- Basic packet (BAUD_DIV=4): accept addr=0xA5, data=0x1234.
  - Line carries bytes A5, 34, 12 in that order.
  - Byte 0 bit sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles per bit.
  - Total 120 cycles; pkt_done fires once, at cycle 120 after accept.
- Handshake hold-off: keep cmd_valid=1 with changing data during a packet.
  - cmd_ready stays 0 throughout.
  - Transmitted bytes equal the values latched at accept.
  - The second packet starts after exactly 5 high cycles (BAUD_DIV+1) following the last data bit.
- Reset mid-frame: drive rst=0 during DATA of byte 1.
  - uart_tx=1, busy=0, cmd_ready=0 on the next edge; no pkt_done.
  - After release, a new packet with addr=0x00, data=0xFFFF transmits correctly.
- Loopback: connect uart_tx to the UART command receiver at the same BAUD_DIV=16 and send addr=0x5A, data=0xBEEF.
  - Receiver pulses cmd_en with cmd_addr=0x5A and cmd_data=0xBEEF.
  - Repeat for 3 back-to-back packets, all of which must be received.
- Baud accuracy with BAUD_DIV=128 (default): measure every uart_tx edge over one packet. All edges land on multiples of 128 cycles from the start-bit edge; total packet is 3840 cycles.

Source files
------------

// File: rtl/command_tx.sv
// UART 8N1 command transmitter: sends {addr, data[7:0], data[15:8]} as three
// back-to-back bytes, LSB first, BAUD_DIV clocks per bit.
module command_tx #(
  parameter int BAUD_DIV = 128
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        pkt_done
);

  localparam int            CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [23:0]   pkt, pkt_n;
  logic          accept, bit_end;
  logic          tx_d, ready_d, busy_d, done_d;

  assign accept  = cmd_valid & cmd_ready;
  assign bit_end = (baud_cnt == BAUD_LAST);

  // NOTE: reset is sampled on the clock edge, and every register here uses <=
  // so all flops update together from values computed in the previous cycle.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      pkt       <= '0;
      uart_tx   <= 1'b1;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      byte_idx  <= byte_idx_n;
      pkt       <= pkt_n;
      uart_tx   <= tx_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      pkt_done  <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n    = state;
    baud_cnt_n = CW'(baud_cnt + 1'b1);
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    pkt_n      = pkt;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (accept) begin
          state_n    = START;
          bit_idx_n  = '0;
          byte_idx_n = '0;
          pkt_n      = {cmd_data, cmd_addr};
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          bit_idx_n  = '0;
          baud_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (byte_idx == 2'd2) begin
            state_n = IDLE;
          end else begin
            state_n    = START;
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes
  // on the same edge as the state, keeping bit boundaries exact.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_n)
      IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        done_d  = (state == STOP);
      end
      START:   tx_d = 1'b0;
      DATA:    tx_d = pkt_n[{byte_idx_n, bit_idx_n}];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_command_tx.sv
// Directed bench for command_tx: framing, handshake hold-off, reset abort,
// serial loopback decode and baud-edge alignment.
module tb_command_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        v4, v16, v128;
  logic        r4, r16, r128;
  logic        tx4, tx16, tx128;
  logic        b4, b16, b128;
  logic        d4, d16, d128;

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;
  int div = 4;
  logic line;

  always #5 clk = ~clk;

  command_tx #(.BAUD_DIV(4)) u4 (
    .i_clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(r4), .cmd_addr(addr),
    .cmd_data(data), .uart_tx(tx4), .busy(b4), .pkt_done(d4));
  command_tx #(.BAUD_DIV(16)) u16 (
    .i_clk(clk), .rst(rst), .cmd_valid(v16), .cmd_ready(r16), .cmd_addr(addr),
    .cmd_data(data), .uart_tx(tx16), .busy(b16), .pkt_done(d16));
  command_tx #(.BAUD_DIV(128)) u128 (
    .i_clk(clk), .rst(rst), .cmd_valid(v128), .cmd_ready(r128), .cmd_addr(addr),
    .cmd_data(data), .uart_tx(tx128), .busy(b128), .pkt_done(d128));

  assign line = (sel == 1) ? tx16 : (sel == 2) ? tx128 : tx4;

  logic w_tx   [0:511];
  logic w_rdy  [0:511];
  logic w_done [0:511];
  logic w_busy [0:511];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample index k is taken on the falling edge after the k-th rising edge
  // following the accept edge (k = 0).
  task automatic capture(input int n, input bit churn);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w_tx[k]   = tx4;
      w_rdy[k]  = r4;
      w_done[k] = d4;
      w_busy[k] = b4;
      if (!churn) begin
        if (k == 0) v4 = 1'b0;
      end else if (k <= 120) begin
        addr = 8'(k);
        data = {8'(k), ~8'(k)};
      end else begin
        v4 = 1'b0;
      end
    end
  endtask

  function automatic logic exp_bit(input logic [23:0] p, input int k);
    int b, pos, byt;
    b   = k / 4;
    pos = b % 10;
    byt = b / 10;
    if (b >= 30 || pos == 9) return 1'b1;
    if (pos == 0) return 1'b0;
    return p[byt*8 + pos - 1];
  endfunction

  function automatic int wave_errs(input logic [23:0] p, input int base, input int n);
    int e;
    e = 0;
    for (int k = 0; k < n; k++)
      if (w_tx[base + k] !== exp_bit(p, k)) e++;
    return e;
  endfunction

  function automatic logic [7:0] dec_byte(input int base, input int b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w_tx[base + (b*10 + 1 + i)*4 + 2];
    return r;
  endfunction

  function automatic int count_hi_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (w_done[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_hi_rdy(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (w_rdy[k] !== 1'b0) c++;
    return c;
  endfunction

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t;
    ok = 1'b1;
    b  = '0;
    t  = 0;
    while (line !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      ok = 1'b0;
      return;
    end
    repeat (div / 2) @(negedge clk);
    if (line !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = line;
    end
    repeat (div) @(negedge clk);
    if (line !== 1'b1) ok = 1'b0;
  endtask

  logic [7:0]  lb_addr [0:2];
  logic [15:0] lb_data [0:2];
  logic [23:0] rx_pk   [0:2];
  bit          rx_ok   [0:2];

  initial begin
    logic [9:0] seq;
    int         run, t, edges, bad, done_at;
    logic       prev;

    rst = 1'b0; v4 = 1'b0; v16 = 1'b0; v128 = 1'b0;
    addr = '0; data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx4, 1'b1);
    check("rst_ready", r4, 1'b0);
    check("rst_busy", b4, 1'b0);
    check("rst_done", d4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", r4, 1'b1);

    // Basic packet A5 / 1234
    addr = 8'hA5; data = 16'h1234; v4 = 1'b1;
    @(posedge clk);
    capture(125, 1'b0);
    check("basic_busy0", w_busy[0], 1'b1);
    for (int i = 0; i < 10; i++) seq[i] = w_tx[i*4 + 2];
    check("basic_b0_frame", seq, 10'b1101001010);
    check("basic_b1", dec_byte(0, 1), 8'h34);
    check("basic_b2", dec_byte(0, 2), 8'h12);
    check("basic_wave", wave_errs(24'h1234A5, 0, 120), 0);
    check("basic_done_cnt", count_hi_done(0, 124), 1);
    check("basic_done_at120", w_done[120], 1'b1);
    check("basic_busy119", w_busy[119], 1'b1);
    check("basic_busy120", w_busy[120], 1'b0);
    check("basic_ready_off", count_hi_rdy(0, 119), 0);
    check("basic_ready120", w_rdy[120], 1'b1);

    // Hold-off: valid stays high with data churning during the packet
    addr = 8'h3C; data = 16'hC0DE; v4 = 1'b1;
    @(posedge clk);
    capture(250, 1'b1);
    check("hold_ready_off", count_hi_rdy(0, 119), 0);
    check("hold_b0", dec_byte(0, 0), 8'h3C);
    check("hold_b1", dec_byte(0, 1), 8'hDE);
    check("hold_b2", dec_byte(0, 2), 8'hC0);
    run = 0;
    for (int j = 116; j < 250; j++) begin
      if (w_tx[j] !== 1'b1) break;
      run++;
    end
    check("hold_gap", run, 5);
    check("hold_done120", w_done[120], 1'b1);
    check("hold_pkt2_wave", wave_errs(24'h788778, 121, 120), 0);
    check("hold_pkt2_done", w_done[241], 1'b1);

    // Reset during DATA of byte 1
    addr = 8'h55; data = 16'h6699; v4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 0) v4 = 1'b0;
    end
    check("abort_line_low", tx4, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_tx", tx4, 1'b1);
    check("abort_busy", b4, 1'b0);
    check("abort_ready", r4, 1'b0);
    check("abort_done", d4, 1'b0);
    rst = 1'b1;
    t = 0;
    run = 0;
    while (r4 !== 1'b1 && t < 10) begin
      @(negedge clk);
      if (d4 === 1'b1) run++;
      t++;
    end
    check("abort_ready_back", r4, 1'b1);
    check("abort_no_done", run, 0);
    addr = 8'h00; data = 16'hFFFF; v4 = 1'b1;
    @(posedge clk);
    capture(125, 1'b0);
    check("abort_new_wave", wave_errs(24'hFFFF00, 0, 120), 0);
    check("abort_new_b0", dec_byte(0, 0), 8'h00);
    check("abort_new_b2", dec_byte(0, 2), 8'hFF);
    check("abort_new_done", count_hi_done(0, 124), 1);

    // Loopback at BAUD_DIV=16, three back-to-back packets
    sel = 1; div = 16;
    lb_addr[0] = 8'h5A; lb_data[0] = 16'hBEEF;
    lb_addr[1] = 8'hC3; lb_data[1] = 16'h0001;
    lb_addr[2] = 8'h7E; lb_data[2] = 16'h8000;
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          int tw;
          @(negedge clk);
          addr = lb_addr[p]; data = lb_data[p]; v16 = 1'b1;
          tw = 0;
          while (r16 !== 1'b1 && tw < 2000) begin
            @(negedge clk);
            tw++;
          end
          check("lb_drv_ready", r16, 1'b1);
          @(posedge clk);
        end
        @(negedge clk);
        v16 = 1'b0;
      end
      begin
        for (int p = 0; p < 3; p++) begin
          logic [7:0] b0, b1, b2;
          bit o0, o1, o2;
          rx_byte(b0, o0);
          rx_byte(b1, o1);
          rx_byte(b2, o2);
          rx_pk[p] = {b2, b1, b0};
          rx_ok[p] = o0 & o1 & o2;
        end
      end
    join
    for (int p = 0; p < 3; p++) begin
      check("lb_frame_ok", rx_ok[p], 1'b1);
      check("lb_addr", rx_pk[p][7:0], lb_addr[p]);
      check("lb_data", rx_pk[p][23:8], lb_data[p]);
    end

    // Baud alignment at BAUD_DIV=128
    sel = 2; div = 128;
    @(negedge clk);
    addr = 8'h55; data = 16'hAAAA; v128 = 1'b1;
    t = 0;
    while (r128 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("baud_ready", r128, 1'b1);
    @(posedge clk);
    prev = 1'b1; edges = 0; bad = 0; done_at = -1;
    for (int k = 0; k < 3846; k++) begin
      @(negedge clk);
      if (k == 0) v128 = 1'b0;
      if (tx128 !== prev) begin
        edges++;
        if (k % 128 != 0) bad++;
      end
      if (d128 === 1'b1 && done_at < 0) done_at = k;
      prev = tx128;
    end
    check("baud_edges", edges, 26);
    check("baud_misaligned", bad, 0);
    check("baud_total", done_at, 3840);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
